// File: rtl/latch_dump_ctrl.sv
// Walks a fixed table of latch-select codes, captures each 32-bit latch word
// from the mux and streams it as four bytes to a UART transmitter.
module latch_dump_ctrl #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_mux_data,
  input  logic        i_tx_ready,
  output logic [6:0]  o_mux_sel,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT, S_CAPTURE, S_SEND, S_NEXT, S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd18;

  state_t      state;
  logic [4:0]  idx;
  logic [1:0]  cnt;
  logic [31:0] word_buf;

  function automatic logic [6:0] code_of(input logic [4:0] i);
    case (i)
      5'd0:    return 7'h00;
      5'd1:    return 7'h01;
      5'd2:    return 7'h10;
      5'd3:    return 7'h11;
      5'd4:    return 7'h12;
      5'd5:    return 7'h13;
      5'd6:    return 7'h14;
      5'd7:    return 7'h15;
      5'd8:    return 7'h20;
      5'd9:    return 7'h21;
      5'd10:   return 7'h23;
      5'd11:   return 7'h24;
      5'd12:   return 7'h25;
      5'd13:   return 7'h30;
      5'd14:   return 7'h31;
      5'd15:   return 7'h32;
      5'd16:   return 7'h33;
      5'd17:   return 7'h40;
      5'd18:   return 7'h41;
      default: return 7'h00;
    endcase
  endfunction

  // Byte n of the transmit order; MSB_FIRST maps n=0 to bits [31:24].
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] n);
    logic [1:0] k;
    k = MSB_FIRST ? (2'd3 - n) : n;
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 5'd0;
      cnt        <= 2'd0;
      word_buf   <= 32'd0;
      o_mux_sel  <= 7'h00;
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            idx    <= 5'd0;
            o_busy <= 1'b1;
            state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          o_mux_sel <= code_of(idx);
          state     <= S_WAIT;
        end
        // The mux registers its output, so the word is not usable until CAPTURE.
        S_WAIT: state <= S_CAPTURE;
        S_CAPTURE: begin
          word_buf   <= i_mux_data;
          cnt        <= 2'd0;
          o_tx_data  <= pick_byte(i_mux_data, 2'd0);
          o_tx_valid <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_ready) begin
            if (cnt == 2'd3) begin
              o_tx_valid <= 1'b0;
              state      <= S_NEXT;
            end else begin
              cnt       <= cnt + 2'd1;
              o_tx_data <= pick_byte(word_buf, cnt + 2'd1);
            end
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx   <= idx + 5'd1;
            state <= S_SELECT;
          end
        end
        S_DONE: begin
          o_mux_sel <= 7'h00;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_dump_ctrl.sv
// Scoreboard bench for latch_dump_ctrl: one instance per byte order, each fed
// by a registered mux model keyed on the select code it drives.
module tb_latch_dump_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, ready0 = 1'b0;
  logic [31:0] mux0;
  logic [6:0]  sel0;
  logic [7:0]  txd0;
  logic        txv0, busy0, done0;

  logic        start1 = 1'b0, ready1 = 1'b0;
  logic [31:0] mux1;
  logic [6:0]  sel1;
  logic [7:0]  txd1;
  logic        txv1, busy1, done1;

  latch_dump_ctrl dut0 (
    .clk(clk), .rst(rst), .i_start(start0), .i_mux_data(mux0), .i_tx_ready(ready0),
    .o_mux_sel(sel0), .o_tx_data(txd0), .o_tx_valid(txv0), .o_busy(busy0), .o_done(done0)
  );

  latch_dump_ctrl #(.MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_mux_data(mux1), .i_tx_ready(ready1),
    .o_mux_sel(sel1), .o_tx_data(txd1), .o_tx_valid(txv1), .o_busy(busy1), .o_done(done1)
  );

  function automatic logic [31:0] model0(input logic [6:0] c);
    return {8'hA5, {1'b0, c}, ~{1'b0, c}, 8'h5A};
  endfunction

  function automatic logic [31:0] model1(input logic [6:0] c);
    return (c == 7'h00) ? 32'h11223344 : {8'hC3, {1'b0, c}, 8'h3C, ~{1'b0, c}};
  endfunction

  // Registered mux: the word for a new code is valid one clock after it changes.
  always @(posedge clk) begin
    mux0 <= model0(sel0);
    mux1 <= model1(sel1);
  end

  logic [6:0] tbl [19] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15, 7'h20,
                           7'h21, 7'h23, 7'h24, 7'h25, 7'h30, 7'h31, 7'h32, 7'h33, 7'h40, 7'h41};

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [6:0] exp_sel_q[$];

  task automatic push_dump(input bit lsb);
    logic [31:0] w;
    for (int i = 0; i < 19; i++) begin
      w = lsb ? model1(tbl[i]) : model0(tbl[i]);
      exp_sel_q.push_back(tbl[i]);
      for (int b = 0; b < 4; b++)
        exp_q.push_back(lsb ? w[8*b +: 8] : w[8*(3-b) +: 8]);
    end
  endtask

  // Leaves the caller at the negedge inside the first SELECT cycle.
  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (sel0 !== 7'h00) begin n_bad++; $display("FAIL reset_sel: got %h want 00", sel0); end
    if (txd0 !== 8'h00) begin n_bad++; $display("FAIL reset_txd: got %h want 00", txd0); end
    if (txv0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", txv0); end
    if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done0); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL idle_wait: busy %b/%b want 0/0", busy0, busy1);
    end
  endtask

  task automatic test_reset_mid_dump;
    int nbytes = 0;
    int cyc = 0;
    bit hit = 1'b0;
    bit stray = 1'b0;
    logic [7:0] e;
    push_dump(1'b0);
    ready0 = 1'b1;
    pulse_start(0);
    while (cyc < 400 && !hit) begin
      if (nbytes == 30 && txv0) hit = 1'b1;
      else begin
        if (txv0 && ready0) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (txd0 !== e) begin n_bad++; $display("FAIL abort_byte%0d: got %h want %h", nbytes, txd0, e); end
          nbytes++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL abort_reach: bytes %0d want 30 with valid", nbytes); end
    #2 rst = 1'b1;
    #1;
    n_cmp += 3;
    if (txv0 !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", txv0); end
    if (sel0 !== 7'h00) begin n_bad++; $display("FAIL abort_sel: got %h want 00", sel0); end
    if (busy0 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy0); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_sel_q.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txv0 || done0 || busy0) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin n_bad++; $display("FAIL abort_quiet: activity %b want 0", stray); end
  endtask

  task automatic test_full_dump;
    int nbytes = 0;
    int cyc = 1;
    int done_cyc = 0;
    bit illegal = 1'b0;
    bit in_tbl;
    logic [7:0] e;
    logic [6:0] es;
    push_dump(1'b0);
    ready0 = 1'b1;
    pulse_start(0);
    while (cyc <= 400 && done_cyc == 0) begin
      in_tbl = 1'b0;
      for (int i = 0; i < 19; i++) if (sel0 === tbl[i]) in_tbl = 1'b1;
      if (!in_tbl) illegal = 1'b1;
      if (txv0 && ready0) begin
        if (nbytes % 4 == 0) begin
          es = (exp_sel_q.size() > 0) ? exp_sel_q.pop_front() : 7'h7F;
          n_cmp++;
          if (sel0 !== es) begin n_bad++; $display("FAIL full_sel%0d: got %h want %h", nbytes / 4, sel0, es); end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (txd0 !== e) begin n_bad++; $display("FAIL full_byte%0d: got %h want %h", nbytes, txd0, e); end
        nbytes++;
      end
      if (done0) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp += 4;
    if (nbytes != 76) begin n_bad++; $display("FAIL full_count: got %0d want 76", nbytes); end
    if (done_cyc != 153) begin n_bad++; $display("FAIL full_done_cycle: got %0d want 153", done_cyc); end
    if (illegal) begin n_bad++; $display("FAIL full_code_range: out-of-table code %b want 0", illegal); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_leftover: got %0d want 0", exp_q.size()); end
    @(negedge clk);
    n_cmp += 3;
    if (busy0 !== 1'b0) begin n_bad++; $display("FAIL full_idle_busy: got %b want 0", busy0); end
    if (sel0 !== 7'h00) begin n_bad++; $display("FAIL full_idle_sel: got %h want 00", sel0); end
    if (done0 !== 1'b0) begin n_bad++; $display("FAIL full_done_width: got %b want 0", done0); end
  endtask

  task automatic test_stall;
    int nbytes = 0;
    int cyc = 0;
    int k = 0;
    bit done_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic [7:0] e;
    push_dump(1'b0);
    ready0 = 1'b1;
    pulse_start(0);
    while (cyc < 800 && !done_seen) begin
      ready0 = (k % 4 == 0) || (k % 4 == 3);
      k++;
      if (prev_stall) begin
        n_cmp++;
        if (txv0 !== 1'b1 || txd0 !== prev_d) begin
          n_bad++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", txv0, txd0, prev_d);
        end
      end
      prev_stall = txv0 && !ready0;
      prev_d = txd0;
      if (txv0 && ready0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (txd0 !== e) begin n_bad++; $display("FAIL stall_byte%0d: got %h want %h", nbytes, txd0, e); end
        nbytes++;
      end
      if (done0) done_seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    ready0 = 1'b1;
    exp_sel_q.delete();
    n_cmp += 2;
    if (!done_seen) begin n_bad++; $display("FAIL stall_done: timeout at %0d cycles", cyc); end
    if (nbytes != 76) begin n_bad++; $display("FAIL stall_count: got %0d want 76", nbytes); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int nbytes = 0;
    int cyc = 1;
    bit done_seen = 1'b0;
    bit restarted = 1'b0;
    logic [7:0] e;
    push_dump(1'b0);
    ready0 = 1'b1;
    pulse_start(0);
    while (cyc < 400 && !done_seen) begin
      start0 = (cyc == 10) || (cyc == 50) || (cyc == 120) || done0;
      if (txv0 && ready0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (txd0 !== e) begin n_bad++; $display("FAIL ign_byte%0d: got %h want %h", nbytes, txd0, e); end
        nbytes++;
      end
      if (done0) done_seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy0 || txv0) restarted = 1'b1;
      @(negedge clk);
    end
    exp_sel_q.delete();
    n_cmp += 3;
    if (!done_seen) begin n_bad++; $display("FAIL ign_done: timeout at %0d cycles", cyc); end
    if (nbytes != 76) begin n_bad++; $display("FAIL ign_count: got %0d want 76", nbytes); end
    if (restarted) begin n_bad++; $display("FAIL ign_requeue: second dump %b want 0", restarted); end
  endtask

  task automatic test_lsb_first;
    int nbytes = 0;
    int cyc = 0;
    bit done_seen = 1'b0;
    logic [7:0] e;
    logic [31:0] first = 32'h0;
    push_dump(1'b1);
    ready1 = 1'b1;
    pulse_start(1);
    while (cyc < 400 && !done_seen) begin
      if (txv1 && ready1) begin
        if (nbytes < 4) first[8*(3-nbytes) +: 8] = txd1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (txd1 !== e) begin n_bad++; $display("FAIL lsb_byte%0d: got %h want %h", nbytes, txd1, e); end
        nbytes++;
      end
      if (done1) done_seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    exp_sel_q.delete();
    n_cmp += 3;
    if (first !== 32'h44332211) begin n_bad++; $display("FAIL lsb_first_word: got %h want 44332211", first); end
    if (nbytes != 76) begin n_bad++; $display("FAIL lsb_count: got %0d want 76", nbytes); end
    if (!done_seen) begin n_bad++; $display("FAIL lsb_done: timeout at %0d cycles", cyc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_dump();
    test_full_dump();
    test_stall();
    test_start_ignored();
    test_lsb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latch_dump_ctrl.md
LATCH_DUMP_CTRL -- requirements
Module: latch_dump_ctrl

Interface
REQ-001 Parameter MSB_FIRST, default 1; 1 = each 32-bit word is sent byte 3 first, 0 = byte 0 first.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_start  input  1  dump request; sampled only in IDLE.
REQ-005 i_mux_data  input  32  registered word from the latch-select mux; valid one clk after o_mux_sel changes.
REQ-006 i_tx_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-007 o_mux_sel  output  7  latch-select code driven to the mux.
REQ-008 o_tx_data  output  8  byte offered to the UART transmitter.
REQ-009 o_tx_valid  output  1  o_tx_data is valid.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_done  output  1  one-cycle pulse after the last byte of a dump is accepted.

Function
REQ-012 The code table SHALL be fixed, 19 entries, in this order: 0x00, 0x01, 0x10, 0x11, 0x12, 0x13, 0x14, 0x15, 0x20, 0x21, 0x23, 0x24, 0x25, 0x30, 0x31, 0x32, 0x33, 0x40, 0x41.
REQ-013 The block SHALL use these FSM states: IDLE, SELECT, WAIT, CAPTURE, SEND, NEXT, DONE.
REQ-014 IDLE: i_start=1 SHALL go to SELECT with entry index 0; i_start=0 SHALL stay in IDLE.
REQ-015 SELECT (1 cycle): o_mux_sel SHALL be registered to table[index]; then go to WAIT.
REQ-016 WAIT (1 cycle): no action; then go to CAPTURE.
REQ-017 CAPTURE (1 cycle): the block SHALL register i_mux_data into a 32-bit word buffer and clear the 2-bit byte counter; then go to SEND.
REQ-018 SEND: o_tx_valid=1; o_tx_data SHALL be the selected byte of the buffer per MSB_FIRST and the byte counter.
REQ-019 o_tx_data SHALL stay stable while o_tx_valid=1 and i_tx_ready=0.
REQ-020 A transfer SHALL occur only on a cycle with o_tx_valid=1 and i_tx_ready=1.
REQ-021 On a transfer with byte counter < 3, the counter SHALL increment and the FSM SHALL stay in SEND; the next byte appears the next cycle.
REQ-022 On a transfer with byte counter = 3, o_tx_valid SHALL drop the next cycle and the FSM SHALL go to NEXT.
REQ-023 NEXT (1 cycle): if index = 18, go to DONE; otherwise increment index and go to SELECT.
REQ-024 DONE (1 cycle): o_done=1; then return to IDLE with o_mux_sel = 0x00.
REQ-025 Each dump SHALL send exactly 76 bytes; index SHALL never exceed 18; no codes outside the table SHALL be driven.
REQ-026 i_start SHALL be ignored in every state except IDLE; there is no queuing.
REQ-027 An i_start asserted in the DONE cycle SHALL have no effect.
REQ-028 i_tx_ready SHALL be ignored in all states except SEND.
REQ-029 o_tx_valid SHALL be 0 in all states except SEND.
REQ-030 With i_tx_ready held at 1, each word SHALL take 8 cycles (SELECT, WAIT, CAPTURE, 4×SEND, NEXT).
REQ-031 With i_tx_ready held at 1, a full dump SHALL take 19×8+1 = 153 cycles from the first SELECT through DONE.

Reset
REQ-032 rst=1 SHALL immediately force: state=IDLE, index=0, byte counter=0, word buffer=0, o_mux_sel=0x00, o_tx_data=0x00, o_tx_valid=0, o_busy=0, o_done=0.
REQ-033 Reset mid-dump SHALL abort the dump with no further bytes offered and no o_done pulse.
REQ-034 After rst deasserts, the block SHALL wait for a new i_start.

Verification
REQ-035 Reset, then one-cycle i_start with i_tx_ready=1 and a mux model returning {0xA5, code, ~code, 0x5A} -> first bytes A5 00 FF 5A, 76 bytes total, o_done exactly 153 cycles after the start edge.
REQ-036 i_tx_ready toggling 1,0,0,1 during SEND -> o_tx_data/o_tx_valid stable through the stalls, no byte dropped or duplicated.
REQ-037 MSB_FIRST=0 with mux word 0x11223344 at code 0x00 -> bytes 44 33 22 11.
REQ-038 Full dump -> o_mux_sel sequence equals the REQ-012 table exactly; 0x02 and 0x22 are never driven.
REQ-039 rst asserted during SEND of word 7 byte 2 -> o_tx_valid=0 and o_mux_sel=0x00 in the same cycle; no o_done; a new i_start restarts at code 0x00.
REQ-040 i_start pulsed while o_busy=1 and in the DONE cycle -> exactly one dump of 76 bytes results.
